// File: rtl/canny_pkg.sv
// Shared types and constants for the Canny stage sequencer
// and the hysteresis stage it drives.
package canny_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE,
    ABORT
  } seq_state_t;

  localparam int unsigned THR_HIGH_DEF = 48;
  localparam int unsigned THR_LOW_DEF  = 12;

  function automatic int unsigned pixel_count(
    input int unsigned w,
    input int unsigned h
  );
    return w * h;
  endfunction

endpackage

// File: rtl/canny_stage_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear and
// synchronous active-low reset.
module sat_counter #(
  parameter int unsigned MAX = 15
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       inc,
  input  logic                       clr,
  output logic [$clog2(MAX+1)-1:0]   count,
  output logic                       at_max
);

  localparam int unsigned W = $clog2(MAX + 1);

  assign at_max = (count == W'(MAX));

  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/canny_stage_sequencer.sv
// Per-frame controller gating one streaming Canny stage
// between the upstream and downstream pixel FIFOs.
module canny_stage_sequencer
  import canny_pkg::*;
#(
  parameter int unsigned WIDTH    = 1280,
  parameter int unsigned HEIGHT   = 720,
  parameter int unsigned TIMEOUT  = 4096,
  parameter int unsigned DEF_HIGH = THR_HIGH_DEF,
  parameter int unsigned DEF_LOW  = THR_LOW_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] cfg_high,
  input  logic [7:0] cfg_low,
  input  logic       up_empty,
  output logic       up_rd_en,
  output logic       stage_in_empty,
  input  logic       stage_in_rd_en,
  input  logic       stage_out_wr_en,
  output logic       stage_out_full,
  input  logic       down_full,
  output logic       down_wr_en,
  output logic       stage_reset,
  output logic [7:0] thr_high,
  output logic [7:0] thr_low,
  output logic       busy,
  output logic       frame_done,
  output logic       err_overflow,
  output logic       err_count,
  output logic       err_timeout
);

  localparam int unsigned PC = pixel_count(WIDTH, HEIGHT);
  localparam int unsigned CW = $clog2(PC + 1);
  localparam int unsigned IW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(PC - 1);

  seq_state_t state, nxt;

  logic [CW-1:0] in_cnt, out_cnt;
  logic [IW-1:0] idle_cnt;
  logic in_max, out_max, idle_max;
  logic in_inc, out_inc, idle_inc, idle_clr;
  logic latch, ovf_set, cnt_set, tmo_set;
  logic cnt_unused;

  assign cnt_unused = ^{out_cnt, idle_cnt};

  sat_counter #(.MAX(PC)) u_in_cnt (
    .clock  (clock),
    .reset  (reset),
    .inc    (in_inc),
    .clr    (latch),
    .count  (in_cnt),
    .at_max (in_max)
  );

  sat_counter #(.MAX(PC)) u_out_cnt (
    .clock  (clock),
    .reset  (reset),
    .inc    (out_inc),
    .clr    (latch),
    .count  (out_cnt),
    .at_max (out_max)
  );

  sat_counter #(.MAX(TIMEOUT - 1)) u_idle_cnt (
    .clock  (clock),
    .reset  (reset),
    .inc    (idle_inc),
    .clr    (idle_clr),
    .count  (idle_cnt),
    .at_max (idle_max)
  );

  assign busy        = (state == RUN) || (state == DRAIN);
  assign frame_done  = (state == DONE);
  assign stage_reset = !reset || (state == ABORT);

  always_comb begin
    nxt            = state;
    up_rd_en       = 1'b0;
    stage_in_empty = 1'b1;
    stage_out_full = 1'b1;
    down_wr_en     = 1'b0;
    in_inc         = 1'b0;
    out_inc        = 1'b0;
    idle_inc       = 1'b0;
    idle_clr       = 1'b0;
    latch          = 1'b0;
    ovf_set        = 1'b0;
    cnt_set        = 1'b0;
    tmo_set        = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          latch = 1'b1;
          nxt   = RUN;
        end
      end
      RUN: begin
        stage_in_empty = up_empty || in_max;
        up_rd_en       = stage_in_rd_en && !stage_in_empty;
        in_inc         = up_rd_en;
        if (up_rd_en && in_cnt == LAST) nxt = DRAIN;
      end
      DRAIN: begin
        idle_inc = !stage_out_wr_en;
        idle_clr = stage_out_wr_en;
        if (out_max) begin
          nxt = DONE;
        end else if (idle_max) begin
          tmo_set = 1'b1;
          nxt     = ABORT;
        end
      end
      DONE: begin
        if (start) begin
          latch = 1'b1;
          nxt   = RUN;
        end else begin
          nxt = IDLE;
        end
      end
      ABORT: nxt = IDLE;
      default: nxt = IDLE;
    endcase
    // Writes past the frame size are blocked; out_cnt saturates.
    if (busy) begin
      stage_out_full = down_full;
      down_wr_en     = stage_out_wr_en && !down_full && !out_max;
      out_inc        = stage_out_wr_en;
      ovf_set        = stage_out_wr_en && down_full;
      cnt_set        = stage_out_wr_en && out_max;
    end else begin
      cnt_set = stage_out_wr_en;
    end
    idle_clr = idle_clr || latch;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      thr_high     <= 8'(DEF_HIGH);
      thr_low      <= 8'(DEF_LOW);
      err_overflow <= 1'b0;
      err_count    <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      state <= nxt;
      if (latch) begin
        thr_high <= cfg_high;
        thr_low  <= cfg_low;
      end
      if (ovf_set) err_overflow <= 1'b1;
      if (cnt_set) err_count    <= 1'b1;
      if (tmo_set) err_timeout  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_canny_stage_sequencer.sv
// Directed bench for canny_stage_sequencer: truth tables for
// the handshake plus multi-cycle frame sequences.
module tb_canny_stage_sequencer;

  logic       clock;
  logic       reset;
  logic       start;
  logic [7:0] cfg_high, cfg_low;
  logic       up_empty, up_rd_en;
  logic       stage_in_empty, stage_in_rd_en;
  logic       stage_out_wr_en, stage_out_full;
  logic       down_full, down_wr_en;
  logic       stage_reset;
  logic [7:0] thr_high, thr_low;
  logic       busy, frame_done;
  logic       err_overflow, err_count, err_timeout;

  canny_stage_sequencer #(
    .WIDTH(8), .HEIGHT(4), .TIMEOUT(16)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .cfg_high        (cfg_high),
    .cfg_low         (cfg_low),
    .up_empty        (up_empty),
    .up_rd_en        (up_rd_en),
    .stage_in_empty  (stage_in_empty),
    .stage_in_rd_en  (stage_in_rd_en),
    .stage_out_wr_en (stage_out_wr_en),
    .stage_out_full  (stage_out_full),
    .down_full       (down_full),
    .down_wr_en      (down_wr_en),
    .stage_reset     (stage_reset),
    .thr_high        (thr_high),
    .thr_low         (thr_low),
    .busy            (busy),
    .frame_done      (frame_done),
    .err_overflow    (err_overflow),
    .err_count       (err_count),
    .err_timeout     (err_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic ue, rd, wr, df;
    logic sie, urd, sof, dwe;
  } vec_t;

  vec_t idle_v[4];
  vec_t run_v[6];

  int checks = 0;
  int errors = 0;

  int up_level, stage_q, wr_limit, wr_issued, full_left;
  int rd_cnt, dw_cnt, done_cnt, drop_cnt, viol, thr_bad;
  int drain_cyc, sr_cnt, drain_at_sr, tmo_at_sr;
  int exp_h, exp_l;
  bit rd_req;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic clr_stats();
    stage_q = 0; wr_issued = 0; full_left = 0;
    rd_cnt = 0; dw_cnt = 0; done_cnt = 0; drop_cnt = 0;
    viol = 0; thr_bad = 0; drain_cyc = 0; sr_cnt = 0;
    drain_at_sr = -1; tmo_at_sr = -1;
  endtask

  // One clock: drive models, sample just after settling, then edge.
  task automatic cyc();
    logic wr;
    wr = (stage_q > 0) && (wr_issued < wr_limit);
    if (full_left > 0) begin
      down_full = 1'b1;
      wr = wr && (full_left == 5 || full_left == 3);
    end else begin
      down_full = 1'b0;
    end
    up_empty        = (up_level == 0);
    stage_in_rd_en  = rd_req;
    stage_out_wr_en = wr;
    #1;
    if (busy === 1'b1 && rd_cnt == 32) drain_cyc++;
    if (busy === 1'b1 && (thr_high != 8'(exp_h) || thr_low != 8'(exp_l)))
      thr_bad++;
    if (up_rd_en === 1'b1) begin
      up_level--;
      rd_cnt++;
      stage_q++;
    end
    if (wr) begin
      wr_issued++;
      stage_q--;
    end
    if (down_wr_en === 1'b1) dw_cnt++;
    if (down_full && wr) drop_cnt++;
    if (down_full && down_wr_en === 1'b1) viol++;
    if (frame_done === 1'b1) done_cnt++;
    if (stage_reset === 1'b1 && reset) begin
      if (sr_cnt == 0) begin
        drain_at_sr = drain_cyc;
        tmo_at_sr   = int'(err_timeout);
      end
      sr_cnt++;
    end
    @(posedge clock);
    #1;
    if (full_left > 0) full_left--;
  endtask

  task automatic run_until_done(input int target, input int budget,
                                input string name);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      cyc();
      n++;
    end
    checks++;
    if (done_cnt < target) begin
      errors++;
      $display("FAIL %s wait: frame_done count %0d expected %0d",
               name, done_cnt, target);
    end
  endtask

  task automatic pulse_start(input int h, input int l);
    cfg_high = 8'(h);
    cfg_low  = 8'(l);
    exp_h    = h;
    exp_l    = l;
    start    = 1'b1;
    cyc();
    start    = 1'b0;
  endtask

  initial begin
    idle_v[0] = '{0,1,0,0, 1,0,1,0};
    idle_v[1] = '{0,1,1,0, 1,0,1,0};
    idle_v[2] = '{1,0,1,1, 1,0,1,0};
    idle_v[3] = '{0,0,0,1, 1,0,1,0};
    run_v[0]  = '{0,1,0,0, 0,1,0,0};
    run_v[1]  = '{1,1,0,0, 1,0,0,0};
    run_v[2]  = '{0,0,1,0, 0,0,0,1};
    run_v[3]  = '{0,1,1,1, 0,1,1,0};
    run_v[4]  = '{1,0,1,1, 1,0,1,0};
    run_v[5]  = '{0,0,0,1, 0,0,1,0};

    reset = 1'b0; start = 1'b0; cfg_high = 8'd0; cfg_low = 8'd0;
    up_empty = 1'b1; stage_in_rd_en = 1'b0;
    stage_out_wr_en = 1'b0; down_full = 1'b0;
    rd_req = 1'b0; up_level = 0; wr_limit = 1000;
    exp_h = 48; exp_l = 12;
    clr_stats();

    // Reset state
    cyc();
    cyc();
    chk("rst_busy", busy, 0);
    chk("rst_thr_high", thr_high, 48);
    chk("rst_thr_low", thr_low, 12);
    chk("rst_stage_reset", stage_reset, 1);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_errs", {err_overflow, err_count, err_timeout}, 0);
    reset = 1'b1;
    #1;
    chk("idle_stage_reset", stage_reset, 0);

    // IDLE handshake table
    for (int i = 0; i < 4; i++) begin
      up_empty = idle_v[i].ue; stage_in_rd_en = idle_v[i].rd;
      stage_out_wr_en = idle_v[i].wr; down_full = idle_v[i].df;
      #1;
      chk($sformatf("idle_vec%0d", i),
          {stage_in_empty, up_rd_en, stage_out_full, down_wr_en},
          {idle_v[i].sie, idle_v[i].urd, idle_v[i].sof, idle_v[i].dwe});
    end

    // Test 1: nominal frame
    clr_stats();
    up_level = 40;
    rd_req = 1'b1;
    pulse_start(60, 20);
    chk("t1_busy", busy, 1);
    chk("t1_thr_high", thr_high, 60);
    chk("t1_thr_low", thr_low, 20);
    for (int i = 0; i < 6; i++) begin
      up_empty = run_v[i].ue; stage_in_rd_en = run_v[i].rd;
      stage_out_wr_en = run_v[i].wr; down_full = run_v[i].df;
      #1;
      chk($sformatf("run_vec%0d", i),
          {stage_in_empty, up_rd_en, stage_out_full, down_wr_en},
          {run_v[i].sie, run_v[i].urd, run_v[i].sof, run_v[i].dwe});
    end
    run_until_done(1, 200, "t1");
    repeat (3) cyc();
    chk("t1_reads", rd_cnt, 32);
    chk("t1_writes", dw_cnt, 32);
    chk("t1_done_pulses", done_cnt, 1);
    chk("t1_up_left", up_level, 8);
    chk("t1_thr_stable", thr_bad, 0);
    chk("t1_idle_after", busy, 0);
    chk("t1_errs", {err_overflow, err_count, err_timeout}, 0);

    // Test 2: back-to-back frames with start held high
    clr_stats();
    up_level = 64;
    cfg_high = 8'd60; cfg_low = 8'd20; exp_h = 60; exp_l = 20;
    start = 1'b1;
    cyc();
    repeat (10) cyc();
    cfg_high = 8'd70; cfg_low = 8'd30;
    run_until_done(1, 200, "t2_f1");
    chk("t2_no_idle_gap", busy, 1);
    chk("t2_thr_high_f2", thr_high, 70);
    chk("t2_thr_low_f2", thr_low, 30);
    exp_h = 70; exp_l = 30;
    start = 1'b0;
    run_until_done(2, 200, "t2_f2");
    chk("t2_reads", rd_cnt, 64);
    chk("t2_writes", dw_cnt, 64);
    chk("t2_thr_stable", thr_bad, 0);
    chk("t2_idle_after", busy, 0);

    // Test 3: backpressure drops two writes
    chk("t3_ovf_before", err_overflow, 0);
    clr_stats();
    up_level = 32;
    pulse_start(60, 20);
    repeat (8) cyc();
    full_left = 5;
    run_until_done(1, 200, "t3");
    chk("t3_dropped", drop_cnt, 2);
    chk("t3_wr_while_full", viol, 0);
    chk("t3_writes", dw_cnt, 30);
    chk("t3_done_pulses", done_cnt, 1);
    chk("t3_overflow", err_overflow, 1);
    chk("t3_count_err", err_count, 0);

    // Test 4: stage stalls after 20 outputs
    chk("t4_tmo_before", err_timeout, 0);
    clr_stats();
    wr_limit = 20;
    up_level = 32;
    pulse_start(60, 20);
    for (int n = 0; n < 200 && sr_cnt == 0; n++) cyc();
    chk("t4_abort_seen", sr_cnt, 1);
    chk("t4_drain_cycles", drain_at_sr, 16);
    chk("t4_tmo_at_abort", tmo_at_sr, 1);
    repeat (3) cyc();
    chk("t4_sr_pulses", sr_cnt, 1);
    chk("t4_no_done", done_cnt, 0);
    chk("t4_idle_after", busy, 0);
    chk("t4_reads", rd_cnt, 32);
    chk("t4_tmo_sticky", err_timeout, 1);
    wr_limit = 1000;

    // Test 5: extra write while idle
    chk("t5_cnt_before", err_count, 0);
    stage_out_wr_en = 1'b1;
    down_full = 1'b0;
    #1;
    chk("t5_down_wr_blocked", down_wr_en, 0);
    chk("t5_out_full", stage_out_full, 1);
    @(posedge clock);
    #1;
    stage_out_wr_en = 1'b0;
    chk("t5_count_err", err_count, 1);
    chk("t5_ovf_sticky", err_overflow, 1);

    // Test 6: reset mid-RUN at in_cnt=10
    clr_stats();
    up_level = 32;
    pulse_start(90, 40);
    for (int n = 0; n < 50 && rd_cnt < 10; n++) cyc();
    chk("t6_reads_before", rd_cnt, 10);
    reset = 1'b0;
    cyc();
    chk("t6_busy", busy, 0);
    chk("t6_thr_high", thr_high, 48);
    chk("t6_thr_low", thr_low, 12);
    chk("t6_stage_reset", stage_reset, 1);
    chk("t6_errs", {err_overflow, err_count, err_timeout}, 0);
    reset = 1'b1;
    clr_stats();
    up_level = 32;
    pulse_start(60, 20);
    run_until_done(1, 200, "t6");
    chk("t6_reads", rd_cnt, 32);
    chk("t6_writes", dw_cnt, 32);
    chk("t6_done_pulses", done_cnt, 1);
    chk("t6_errs_after", {err_overflow, err_count, err_timeout}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
